// File: rtl/log2_iter_n.sv
// Iterative base-2 logarithm: integer part from leading-one detection, then F fraction
// bits by repeated squaring of the normalised mantissa, one bit per cycle.
module log2_iter_n #(
  parameter int W  = 16,
  parameter int F  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [IW-1:0] ynguyen_o,
  output logic [F-1:0]  ythapphan_o,
  output logic          err_o,
  output logic          busy_o
);

  localparam int CW = (F > 1) ? $clog2(F) : 1;

  typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

  // Highest set bit position; zero input yields 0.
  function automatic logic [IW-1:0] lead_one(input logic [W-1:0] x);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      if (x[i]) r = IW'(i);
    return r;
  endfunction

  // One squaring step on a Q1.(W-1) mantissa: returns {bit, renormalised mantissa}, truncated.
  function automatic logic [W:0] sq_step(input logic [W-1:0] m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, m} * {{W{1'b0}}, m};
    if (p[2*W-1]) return {1'b1, p[2*W-1:W]};
    else          return {1'b0, p[2*W-2:W-1]};
  endfunction

  state_t          state;
  logic [W-1:0]    x_p0;
  logic [W-1:0]    m_p1;
  logic [IW-1:0]   k_p1;
  logic            err_p1;
  logic [F-1:0]    frac_p1;
  logic [CW-1:0]   cnt;

  logic [IW-1:0]   k_w;
  logic [W:0]      step_w;
  logic [F-1:0]    frac_nxt;

  assign k_w      = lead_one(x_p0);
  assign step_w   = sq_step(m_p1);
  assign frac_nxt = F'({frac_p1, step_w[W]});

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      x_p0        <= '0;
      m_p1        <= '0;
      k_p1        <= '0;
      err_p1      <= 1'b0;
      frac_p1     <= '0;
      cnt         <= '0;
      ynguyen_o   <= '0;
      ythapphan_o <= '0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        // operand capture
        IDLE: begin
          if (in_valid_i && in_ready_o) begin
            x_p0       <= data_i;
            state      <= NORM;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        // normalise: mantissa into [1,2), integer part from leading one
        NORM: begin
          k_p1    <= k_w;
          m_p1    <= x_p0 << (IW'(W-1) - k_w);
          err_p1  <= (x_p0 == '0);
          frac_p1 <= '0;
          cnt     <= '0;
          state   <= ITER;
        end
        // one fraction bit per cycle, first bit ends up as MSB
        ITER: begin
          m_p1    <= step_w[W-1:0];
          frac_p1 <= frac_nxt;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(F-1)) begin
            state       <= DONE;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b1;
            ynguyen_o   <= err_p1 ? '0 : k_p1;
            ythapphan_o <= err_p1 ? '0 : frac_nxt;
            err_o       <= err_p1;
          end
        end
        // hold result until consumed
        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/log2_iter_n.md
Name: log2_iter_n

Overview:
Parametrised iterative base-2 logarithm unit: the next generation of the team's 16-bit squaring-method log2 block. It generalises input width and fraction precision and replaces the free-running start flag with a valid/ready handshake on both sides. It flags zero input and holds its result under output back-pressure. It sits between sample-conditioning logic and downstream dB/scaling arithmetic.

Parameters:
W, 16, input width in bits (4..32)
F, 8, number of fractional result bits produced (1..W-1)
IW, $clog2(W), integer-part width (derived; not overridden)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-low
in_valid_i  in  1  operand present
in_ready_o  out  1  unit can accept operand
data_i  in  W  unsigned operand x
out_valid_o  out  1  result present
out_ready_i  in  1  consumer accepts result
ynguyen_o  out  IW  integer part floor(log2 x)
ythapphan_o  out  F  fractional part, MSB = 2^-1 weight
err_o  out  1  x was zero; ynguyen_o/ythapphan_o forced 0
busy_o  out  1  high in NORM or ITER

Behaviour:
- Reset: rst_i=0 at a rising edge puts the unit in IDLE and clears all registers. Outputs: in_ready_o=1, out_valid_o=0, ynguyen_o=0, ythapphan_o=0, err_o=0, busy_o=0. Reset mid-operation aborts the operation; no result is emitted.
- FSM states: IDLE, NORM, ITER, DONE.
- IDLE: in_ready_o=1. On in_valid_i&in_ready_o, latch x and go to NORM. in_ready_o=0 in every other state. No second operand is accepted until the current result has been consumed.
- NORM (1 cycle):
  - Leading-one detect: k = index of highest set bit of x, giving ynguyen_o = k.
  - Mantissa m = x << (W-1-k), interpreted as Q1.(W-1) in [1,2).
  - If x=0: latch err=1 and k=0. The FSM still runs ITER with the fraction forced to 0, so latency stays uniform.
  - Clear the iteration counter and go to ITER.
- ITER (exactly F cycles, counter 0..F-1):
  - P = m*m as a 2W-bit product, Q2.(2W-2).
  - If P[2W-1]=1: bit=1 and m <= P[2W-1:W]. Otherwise bit=0 and m <= P[2W-2:W-1]. Truncation only, no rounding.
  - Shift bit into the fraction LSB-first from the right (frac <= {frac[F-2:0],bit}), so the first-computed bit ends as MSB.
  - Single-cycle WxW multiply. When the counter reaches F-1, go to DONE.
- DONE:
  - out_valid_o=1. ynguyen_o, ythapphan_o and err_o are stable and held until out_valid_o&out_ready_i.
  - On handshake, go to IDLE. out_valid_o drops and in_ready_o rises on the following cycle.
- Latency: operand accepted at edge t gives out_valid_o=1 after edge t+F+1 (NORM + F ITER cycles). With out_ready_i held high, throughput is one result per F+3 cycles.
- Outputs are registered. Result fields are updated only on entry to DONE and cleared on reset. They are not cleared by the handshake and keep their last value in IDLE.
- in_valid_i asserted while not in IDLE is ignored; the operand is not captured. data_i need only be stable in the accept cycle.
- out_ready_i asserted outside DONE has no effect.
- Arithmetic is bit-exact to the description above. The bench model must use identical truncation.

Test Plan:
- W=16,F=8 reset: hold rst_i=0 for 2 cycles with in_valid_i=1 -> in_ready_o=1, out_valid_o=0, all result fields 0, no capture; release, then x=1 -> ynguyen_o=0, ythapphan_o=0x00, err_o=0.
- x=2, x=0x8000, x=3 -> (1,0x00), (15,0x00), (1,0x95); out_valid_o rises exactly 9 cycles after each accept edge.
- x=0xFFFF -> ynguyen_o=15, ythapphan_o=0xFF; x=0 -> err_o=1, ynguyen_o=0, ythapphan_o=0x00, same 9-cycle latency.
- Back-pressure: x=3 with out_ready_i=0 for 20 cycles -> out_valid_o and result stay held and in_ready_o stays 0. Toggle data_i/in_valid_i meanwhile -> no capture. Raise out_ready_i -> one handshake, in_ready_o=1 next cycle.
- Reset mid-ITER: drop rst_i for 1 cycle at iteration 4 of x=3 -> no out_valid_o pulse, IDLE outputs. A following x=2 returns (1,0x00).
- Parameter sweep: W=8,F=4 with x=255 -> (7,0xF); W=32,F=16 random 1000 operands checked bit-exactly against the model, with latency F+1 after accept.
